riscv_trap_controller: RTL and testbench

Machine-mode trap controller: the consumer end of the misaligned-address exception flags raised in the execute stage. It prioritises the flags, captures `mepc`/`mcause`/`mtval`, flushes the pipeline and redirects fetch to `mtvec`. It also executes `mret` by redirecting fetch to `mepc`, and owns a small CSR read/write port. It sits between the execute/memory boundary and the PC-select / hazard logic.

---
 rtl/riscv_trap_controller.sv | 140 ++++++++++++++
 tb/tb_riscv_trap_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trap_controller.sv
// Machine-mode trap controller: prioritises misaligned-address flags, captures mepc/mcause/mtval,
// flushes and redirects fetch to mtvec, and handles mret. Define RISCV_TRAP_MTVAL_EN to build mtval.
module riscv_trap_controller #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            i_riscv_trap_clk,
  input  logic            i_riscv_trap_rst_n,
  input  logic            i_riscv_trap_inst_addr_misaligned,
  input  logic            i_riscv_trap_load_addr_misaligned,
  input  logic            i_riscv_trap_store_addr_misaligned,
  input  logic [XLEN-1:0] i_riscv_trap_pc,
  input  logic [XLEN-1:0] i_riscv_trap_fault_addr,
  input  logic            i_riscv_trap_mret,
  input  logic            i_riscv_trap_csr_we,
  input  logic [11:0]     i_riscv_trap_csr_addr,
  input  logic [XLEN-1:0] i_riscv_trap_csr_wdata,
  output logic [XLEN-1:0] o_riscv_trap_csr_rdata,
  output logic            o_riscv_trap_flush,
  output logic            o_riscv_trap_redirect,
  output logic [XLEN-1:0] o_riscv_trap_redirect_pc,
  output logic            o_riscv_trap_busy
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  typedef enum logic [1:0] {StIdle, StTrap, StVector, StReturn} state_e;

  state_e          state_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
`ifdef RISCV_TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_q;
`else
  logic            unused_fault;
  assign unused_fault = ^i_riscv_trap_fault_addr;
`endif

  logic            any_flag;
  logic [XLEN-1:0] cause;
  logic            unused_pc_lsb;

  assign any_flag      = i_riscv_trap_inst_addr_misaligned | i_riscv_trap_load_addr_misaligned |
                         i_riscv_trap_store_addr_misaligned;
  assign unused_pc_lsb = i_riscv_trap_pc[0];

  // Interrupt bit is always 0: only synchronous exceptions reach this block.
  always_comb begin
    cause = '0;
    if (i_riscv_trap_inst_addr_misaligned) begin
      cause = XLEN'(0);
    end else if (i_riscv_trap_load_addr_misaligned) begin
      cause = XLEN'(4);
    end else if (i_riscv_trap_store_addr_misaligned) begin
      cause = XLEN'(6);
    end
  end

  always_comb begin
    o_riscv_trap_csr_rdata = '0;
    case (i_riscv_trap_csr_addr)
      ADDR_MTVEC:  o_riscv_trap_csr_rdata = mtvec_q;
      ADDR_MEPC:   o_riscv_trap_csr_rdata = mepc_q;
      ADDR_MCAUSE: o_riscv_trap_csr_rdata = mcause_q;
`ifdef RISCV_TRAP_MTVAL_EN
      ADDR_MTVAL:  o_riscv_trap_csr_rdata = mtval_q;
`else
      ADDR_MTVAL:  o_riscv_trap_csr_rdata = '0;
`endif
      default:     o_riscv_trap_csr_rdata = '0;
    endcase
  end

  always_ff @(posedge i_riscv_trap_clk) begin
    if (!i_riscv_trap_rst_n) begin
      state_q                  <= StIdle;
      mtvec_q                  <= MTVEC_RESET;
      mepc_q                   <= '0;
      mcause_q                 <= '0;
`ifdef RISCV_TRAP_MTVAL_EN
      mtval_q                  <= '0;
`endif
      o_riscv_trap_flush       <= 1'b0;
      o_riscv_trap_busy        <= 1'b0;
      o_riscv_trap_redirect    <= 1'b0;
      o_riscv_trap_redirect_pc <= '0;
    end else begin
      o_riscv_trap_flush       <= 1'b0;
      o_riscv_trap_busy        <= 1'b0;
      o_riscv_trap_redirect    <= 1'b0;
      o_riscv_trap_redirect_pc <= '0;
      unique case (state_q)
        StIdle: begin
          // Exception beats mret and suppresses the CSR write of the faulting instruction.
          if (any_flag) begin
            state_q            <= StTrap;
            mepc_q             <= {i_riscv_trap_pc[XLEN-1:1], 1'b0};
            mcause_q           <= cause;
`ifdef RISCV_TRAP_MTVAL_EN
            mtval_q            <= i_riscv_trap_fault_addr;
`endif
            o_riscv_trap_flush <= 1'b1;
            o_riscv_trap_busy  <= 1'b1;
          end else if (i_riscv_trap_mret) begin
            state_q                  <= StReturn;
            o_riscv_trap_flush       <= 1'b1;
            o_riscv_trap_busy        <= 1'b1;
            o_riscv_trap_redirect    <= 1'b1;
            o_riscv_trap_redirect_pc <= mepc_q;
          end else if (i_riscv_trap_csr_we) begin
            case (i_riscv_trap_csr_addr)
              ADDR_MTVEC:  mtvec_q  <= {i_riscv_trap_csr_wdata[XLEN-1:2], 2'b00};
              ADDR_MEPC:   mepc_q   <= {i_riscv_trap_csr_wdata[XLEN-1:1], 1'b0};
              ADDR_MCAUSE: mcause_q <= i_riscv_trap_csr_wdata;
`ifdef RISCV_TRAP_MTVAL_EN
              ADDR_MTVAL:  mtval_q  <= i_riscv_trap_csr_wdata;
`endif
              default: ;
            endcase
          end
        end
        StTrap: begin
          state_q                  <= StVector;
          o_riscv_trap_flush       <= 1'b1;
          o_riscv_trap_busy        <= 1'b1;
          o_riscv_trap_redirect    <= 1'b1;
          o_riscv_trap_redirect_pc <= mtvec_q;
        end
        StVector: state_q <= StIdle;
        StReturn: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_trap_controller.sv
// Randomised self-checking bench for riscv_trap_controller against a queue-based behavioural model.
module tb_riscv_trap_controller;

  localparam logic [63:0] MTV_RST = 64'h400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_inst, f_load, f_store, mret, csr_we;
  logic [63:0] pc, fault, wdata, rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic        flush, redirect, busy;

  riscv_trap_controller #(.XLEN(64), .MTVEC_RESET(MTV_RST)) dut (
    .i_riscv_trap_clk                   (clk),
    .i_riscv_trap_rst_n                 (rst_n),
    .i_riscv_trap_inst_addr_misaligned  (f_inst),
    .i_riscv_trap_load_addr_misaligned  (f_load),
    .i_riscv_trap_store_addr_misaligned (f_store),
    .i_riscv_trap_pc                    (pc),
    .i_riscv_trap_fault_addr            (fault),
    .i_riscv_trap_mret                  (mret),
    .i_riscv_trap_csr_we                (csr_we),
    .i_riscv_trap_csr_addr              (csr_addr),
    .i_riscv_trap_csr_wdata             (wdata),
    .o_riscv_trap_csr_rdata             (rdata),
    .o_riscv_trap_flush                 (flush),
    .o_riscv_trap_redirect              (redirect),
    .o_riscv_trap_redirect_pc           (redirect_pc),
    .o_riscv_trap_busy                  (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: CSR values plus a queue of the output tuples still to be shown.
  typedef struct packed {logic f; logic b; logic r; logic [63:0] pc;} out_t;
  out_t        pend[$];
  out_t        cur = '0;
  logic [63:0] m_mtvec = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0;

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef RISCV_TRAP_MTVAL_EN
      12'h343: return m_mtval;
`endif
      default: return 64'h0;
    endcase
  endfunction

  task model_edge();
    if (!rst_n) begin
      m_mtvec = MTV_RST; m_mepc = '0; m_mcause = '0; m_mtval = '0;
      pend.delete();
      cur = '0;
    end else begin
      if (!cur.b) begin
        if (f_inst || f_load || f_store) begin
          m_mepc   = pc & ~64'h1;
          m_mcause = f_inst ? 64'd0 : (f_load ? 64'd4 : 64'd6);
          m_mtval  = fault;
          pend.push_back('{1'b1, 1'b1, 1'b0, 64'h0});
          pend.push_back('{1'b1, 1'b1, 1'b1, m_mtvec});
        end else if (mret) begin
          pend.push_back('{1'b1, 1'b1, 1'b1, m_mepc});
        end else if (csr_we) begin
          case (csr_addr)
            12'h305: m_mtvec  = wdata & ~64'h3;
            12'h341: m_mepc   = wdata & ~64'h1;
            12'h342: m_mcause = wdata;
            12'h343: m_mtval  = wdata;
            default: ;
          endcase
        end
      end
      cur = (pend.size() != 0) ? pend.pop_front() : '0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("flush", {63'h0, flush}, {63'h0, cur.f});
      chk("busy", {63'h0, busy}, {63'h0, cur.b});
      chk("redirect", {63'h0, redirect}, {63'h0, cur.r});
      chk("redirect_pc", redirect_pc, cur.pc);
      chk("csr_rdata", rdata, m_read(csr_addr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    f_inst = 0; f_load = 0; f_store = 0; mret = 0; csr_we = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

`ifdef RISCV_TRAP_MTVAL_EN
  localparam logic [63:0] EXP_MTVAL = 64'h2001;
`else
  localparam logic [63:0] EXP_MTVAL = 64'h0;
`endif

  initial begin
    rst_n = 0; clr(); pc = '0; fault = '0; wdata = '0; csr_addr = '0;
    cyc(2);
    chk_en = 1'b1;
    rst_n  = 1;
    rd("rst_mtvec", 12'h305, 64'h400);
    rd("rst_mepc", 12'h341, 64'h0);
    rd("rst_mcause", 12'h342, 64'h0);
    rd("rst_mtval", 12'h343, 64'h0);
    chk("rst_ctrl", {61'h0, flush, redirect, busy}, 64'h0);

    csr_we = 1; csr_addr = 12'h305; wdata = 64'h8000_0103;
    cyc(1); clr();
    rd("mtvec_wr", 12'h305, 64'h8000_0100);
    f_load = 1; pc = 64'h1000; fault = 64'h2001;
    cyc(1); clr();
    chk("trap_flush_busy", {62'h0, flush, busy}, 64'h3);
    chk("trap_no_redir", {63'h0, redirect}, 64'h0);
    cyc(1);
    chk("vec_redir", {63'h0, redirect}, 64'h1);
    chk("vec_pc", redirect_pc, 64'h8000_0100);
    cyc(1);
    rd("ld_mepc", 12'h341, 64'h1000);
    rd("ld_mcause", 12'h342, 64'h4);
    rd("ld_mtval", 12'h343, EXP_MTVAL);

    f_inst = 1; f_store = 1; pc = 64'h3001;
    cyc(1); clr(); cyc(2);
    rd("is_mcause", 12'h342, 64'h0);
    mret = 1;
    cyc(1); clr();
    chk("mret_redir", {62'h0, redirect, flush}, 64'h3);
    chk("mret_pc", redirect_pc, 64'h3000);
    cyc(1);
    chk("mret_done", {63'h0, redirect}, 64'h0);

    f_store = 1; csr_we = 1; csr_addr = 12'h305; wdata = 64'hdead_beef;
    cyc(1); clr(); cyc(2);
    rd("st_mcause", 12'h342, 64'h6);
    rd("st_mtvec_kept", 12'h305, 64'h8000_0100);

    f_load = 1; mret = 1; pc = 64'h4000;
    cyc(1); clr();
    chk("flag_mret_trap", {63'h0, redirect}, 64'h0);
    cyc(1);
    chk("flag_mret_vec", redirect_pc, 64'h8000_0100);
    cyc(1);

    f_inst = 1; pc = 64'h5000;
    cyc(1); clr(); f_load = 1; pc = 64'h6000;
    cyc(2); clr();
    rd("ignored_mcause", 12'h342, 64'h0);
    rd("ignored_mepc", 12'h341, 64'h5000);

    f_store = 1; pc = 64'h7000;
    cyc(1); clr(); rst_n = 0;
    cyc(1); rst_n = 1;
    chk("rst_mid_redir", {62'h0, redirect, flush}, 64'h0);
    rd("rst_mid_mepc", 12'h341, 64'h0);
    rd("rst_mid_mtvec", 12'h305, 64'h400);
    cyc(2);

    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      f_inst  = ($urandom_range(0, 11) == 0);
      f_load  = ($urandom_range(0, 9) == 0);
      f_store = ($urandom_range(0, 9) == 0);
      mret    = ($urandom_range(0, 7) == 0);
      csr_we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: csr_addr = 12'h305;
        1: csr_addr = 12'h341;
        2: csr_addr = 12'h342;
        3: csr_addr = 12'h343;
        default: csr_addr = 12'($urandom_range(0, 4095));
      endcase
      wdata = {$urandom, $urandom};
      pc    = {$urandom, $urandom};
      fault = {$urandom, $urandom};
      cyc(1);
    end
    clr(); rst_n = 1;
    cyc(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
